// File: rtl/m72_pkg.sv
// Shared constants and types for the sample fetch engine and its DAC path.
package m72_pkg;

    localparam int unsigned PTR_W = 20;
    localparam int unsigned DAC_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_t;

    // Unsigned DAC byte to signed 16-bit sample: 0x80 is silence.
    function automatic logic [DAC_W-1:0] dac_target(input logic [7:0] b);
        return {b ^ 8'h80, 8'h00};
    endfunction

endpackage

// File: rtl/sample_dac_filter.sv
// One-pole low-pass smoothing of the DAC target, updated once every FILT_DIV clocks.
module sample_dac_filter
    import m72_pkg::*;
#(
    parameter int unsigned FILT_DIV = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DAC_W-1:0] target,
    output logic [DAC_W-1:0] dac_out
);

    localparam int unsigned DIV_W = (FILT_DIV > 1) ? $clog2(FILT_DIV) : 1;

    logic [DIV_W-1:0]        div_cnt;
    logic                    tick_c;
    logic signed [DAC_W:0]   diff_c;
    logic signed [DAC_W:0]   step_c;
    logic signed [DAC_W:0]   sum_c;

    assign tick_c = (div_cnt == DIV_W'(FILT_DIV - 1));

    // 17-bit intermediate: the sum always lands between acc and target, so it fits 16 bits.
    always_comb begin
        diff_c = $signed({target[DAC_W-1], target}) - $signed({dac_out[DAC_W-1], dac_out});
        step_c = diff_c >>> 3;
        sum_c  = $signed({dac_out[DAC_W-1], dac_out}) + step_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            dac_out <= '0;
        end else begin
            div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
            if (tick_c) begin
                dac_out <= DAC_W'(sum_c);
            end
        end
    end

endmodule

// File: rtl/sample_fetch.sv
// Sample ROM pointer, fetch handshake and DAC output stage.
// Build option: SAMPLE_DAC_FILTER_EN inserts a low-pass filter on dac_out.
module sample_fetch
    import m72_pkg::*;
#(
    parameter int unsigned ROM_AW   = 18,
    parameter int unsigned FILT_DIV = 32
) (
    input  logic              CLK_32M,
    input  logic              reset_n,
    input  logic [15:0]       sample_addr,
    input  logic [1:0]        sample_addr_wr,
    input  logic              sample_inc,
    input  logic [7:0]        sample_out,
    output logic [7:0]        sample_in,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_req,
    input  logic              rom_ack,
    input  logic [7:0]        rom_data,
    output logic [15:0]       dac_out
);

    localparam logic [PTR_W-1:0] WRAP_MASK = PTR_W'((64'd1 << ROM_AW) - 64'd1);

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic             ptr_chg;
    logic             pending;
    logic             req_nxt;
    logic             load_addr_c;
    logic             take_data_c;
    logic [DAC_W-1:0] target;

    // Address writes take priority over increments; increments wrap inside the ROM window.
    always_comb begin
        ptr_nxt = ptr;
        ptr_chg = 1'b0;
        if (|sample_addr_wr) begin
            if (sample_addr_wr[0]) ptr_nxt[11:4]  = sample_addr[7:0];
            if (sample_addr_wr[1]) ptr_nxt[19:12] = sample_addr[15:8];
            ptr_nxt[3:0] = 4'h0;
            ptr_chg      = 1'b1;
        end else if (sample_inc) begin
            ptr_nxt = (ptr & ~WRAP_MASK) | ((ptr + PTR_W'(1)) & WRAP_MASK);
            ptr_chg = 1'b1;
        end
    end

    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pending) state_nxt = ST_REQ;
            ST_REQ:  state_nxt = rom_ack ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (rom_ack) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Data from an ack is stale if the pointer moved during, or on, the request.
    always_comb begin
        req_nxt     = 1'b0;
        load_addr_c = 1'b0;
        take_data_c = 1'b0;
        if (state_nxt != ST_IDLE) req_nxt = 1'b1;
        if (state == ST_IDLE && pending) load_addr_c = 1'b1;
        if (state != ST_IDLE && rom_ack && !pending && !ptr_chg) take_data_c = 1'b1;
    end

    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            pending   <= 1'b0;
            rom_addr  <= '0;
            rom_req   <= 1'b0;
            sample_in <= '0;
            target    <= '0;
        end else begin
            ptr     <= ptr_nxt;
            rom_req <= req_nxt;
            if (ptr_chg) begin
                pending <= 1'b1;
            end else if (load_addr_c) begin
                pending <= 1'b0;
            end
            if (load_addr_c) rom_addr  <= ROM_AW'(ptr);
            if (take_data_c) sample_in <= rom_data;
            if (sample_inc)  target    <= dac_target(sample_out);
        end
    end

`ifdef SAMPLE_DAC_FILTER_EN
    sample_dac_filter #(
        .FILT_DIV (FILT_DIV)
    ) u_filter (
        .clk     (CLK_32M),
        .rst_n   (reset_n),
        .target  (target),
        .dac_out (dac_out)
    );
`else
    assign dac_out = target;
`endif

endmodule

// File: doc/sample_fetch.md
SAMPLE_FETCH -- requirements
Module: sample_fetch

Interface
REQ-001 Parameter ROM_AW, default 18: sample ROM byte-address width.
REQ-002 Parameter FILT_DIV, default 32: clocks per DAC filter update (used only with SAMPLE_DAC_FILTER_EN).
REQ-003 CLK_32M  in  1  sole clock; all state is updated on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 sample_addr  in  16  address byte from the Z80 side; bits [7:0] are used for a low write and bits [15:8] for a high write.
REQ-006 sample_addr_wr  in  2  one-cycle strobes: bit0 = low write, bit1 = high write.
REQ-007 sample_inc  in  1  one-cycle strobe: advance the ROM pointer.
REQ-008 sample_out  in  8  unsigned DAC byte, captured when sample_inc is high.
REQ-009 sample_in  out  8  last byte fetched from the ROM at the current pointer.
REQ-010 rom_addr  out  ROM_AW  ROM byte address.
REQ-011 rom_req  out  1  request level.
REQ-012 rom_ack  in  1  one-cycle acknowledge; rom_data is valid in that cycle.
REQ-013 rom_data  in  8  ROM read data.
REQ-014 dac_out  out  16  signed audio sample.

Function
REQ-015 The block SHALL hold a 20-bit pointer ptr.
- Low write: ptr[11:4] <= byte, ptr[3:0] <= 0, ptr[19:12] kept.
- High write: ptr[19:12] <= byte, ptr[3:0] <= 0, ptr[11:4] kept.
REQ-016 If both bits of sample_addr_wr are set in one cycle, the block SHALL apply both writes and clear ptr[3:0].
REQ-017 sample_inc SHALL set ptr <= ptr + 1, wrapping modulo 2^ROM_AW, so ptr[19:ROM_AW] never changes on an increment.
REQ-018 If an address write and sample_inc occur in the same cycle, the address write SHALL win, and sample_out SHALL still be captured.
REQ-019 Every pointer change SHALL set a pending-fetch flag in the same cycle.
REQ-020 FSM states IDLE, REQ, WAIT:
- IDLE -> REQ when pending is set; rom_addr <= ptr[ROM_AW-1:0], pending cleared.
- REQ: drive rom_req = 1 and move to WAIT on the next cycle.
- WAIT: keep rom_req = 1 until rom_ack, then drop it in the cycle after the ack and return to IDLE.
REQ-021 rom_addr SHALL stay stable while rom_req is high.
REQ-022 On rom_ack, sample_in <= rom_data one cycle later, unless pending was set during the request; stale data SHALL then be discarded and a new fetch issued from IDLE.
REQ-023 Latency SHALL be 2 cycles from a pointer change to rom_req rising when idle, and 1 cycle from rom_ack to sample_in updating.
REQ-024 A rom_ack received in IDLE SHALL be ignored.
REQ-025 Unfiltered path: dac_out <= {sample_out ^ 8'h80, 8'h00} on the cycle after sample_inc, i.e. 8'h80 maps to 0, 8'hFF to 0x7F00, 8'h00 to 0x8000.

Reset
REQ-026 On reset_n low the block SHALL asynchronously clear:
- ptr, rom_addr, rom_req, pending, sample_in and dac_out to 0;
- the FSM to IDLE;
- the filter accumulator and divider to 0.
REQ-027 A reset asserted mid-fetch SHALL abandon the request, and a later rom_ack SHALL be ignored.
REQ-028 No fetch SHALL be issued after reset until the first pointer change.

Configuration
REQ-029 Macro SAMPLE_DAC_FILTER_EN.
- Defined: dac_out SHALL be a one-pole low-pass of the REQ-025 target, acc += (target - acc) >>> 3 once every FILT_DIV clocks, in signed 16-bit arithmetic with arithmetic shift and no overflow.
- Undefined: dac_out follows REQ-025 exactly and no filter logic is built.

Structure
REQ-030 The FSM state enum and the pointer-width constant (20) SHALL live in m72_pkg.
REQ-031 The filter SHALL be the one natural sub-module, sample_dac_filter, instantiated only under SAMPLE_DAC_FILTER_EN.

Verification
REQ-032 Low write 0x12 then high write 0x03 -> ptr = 0x03120, rom_addr = 0x03120, rom_req high 2 cycles after the last write.
REQ-033 ROM returns 0xA5 with ack 5 cycles after the request -> sample_in = 0xA5 one cycle after ack, rom_req low.
REQ-034 ptr = 0x3FFFF (ROM_AW = 18) with sample_inc -> ptr wraps to 0x00000 and a fetch is issued at 0.
REQ-035 Low write during WAIT, stale data 0x11 acked -> sample_in unchanged, a second request issued at the new address with data 0x22, sample_in = 0x22.
REQ-036 sample_inc with sample_out 0xFF, then 0x80 -> dac_out 0x7F00, then 0x0000 (filter off); with the filter on, dac_out steps monotonically toward each target.
REQ-037 reset_n pulsed low while rom_req is high -> all outputs 0 immediately, and a following rom_ack leaves sample_in = 0.
